adc_seg_display: RTL and testbench

- Downstream display stage for the I2C/ADS1115 acquisition system.
- Takes each 16-bit ADS1115 conversion result and converts its magnitude to 5 BCD digits with an iterative double-dabble engine.
- Drives six 7-segment digits: sign plus five decimal digits.
- Replaces software-driven LED PIO writes with a hardware path fed by a valid/ready sample handshake.

---
 rtl/adc_seg_display.sv | 183 ++++++++++++++++++
 tb/tb_adc_seg_display.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_seg_display.sv
// adc_seg_display
//
// Display stage for ADS1115 conversion results. Each accepted 16-bit sample
// is reduced to a sign and an unsigned magnitude. The magnitude is turned into
// five BCD digits by an iterative double-dabble engine that handles one bit per
// clock. The result then drives six 7-segment digits: a sign digit followed by
// five decimal digits.
//
// Timing: the sample is accepted on edge E0. Edges E1..E16 do the 16
// shift/adjust steps. Edge E17 registers bcd_out and led1..led6. disp_valid
// and sample_ready are both high in the cycle after E17.
//
// Ports:
//   clk_50Mhz     in   1   system clock, rising edge
//   reset         in   1   synchronous, active-high
//   sample_valid  in   1   sample_data is valid this cycle
//   sample_data   in  16   ADS1115 conversion code
//   sample_ready  out  1   high only while idle; samples offered while low are dropped
//   disp_valid    out  1   one-cycle pulse when bcd_out / led* update
//   bcd_out       out 20   BCD magnitude, digit4..digit0 = [19:16]..[3:0]
//   led1..led5    out  7   ones .. ten-thousands digit, bit0=a .. bit6=g
//   led6          out  7   sign digit (minus or blank)
module adc_seg_display #(
    parameter bit SIGNED_IN      = 1'b1,  // 1: two's complement input, sign on led6
    parameter bit BLANK_LZ       = 1'b1,  // 1: blank leading zeros on led5..led2
    parameter bit SEG_ACTIVE_LOW = 1'b1   // 1: segment lit when its bit is 0
) (
    input  logic        clk_50Mhz,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        sample_ready,
    output logic        disp_valid,
    output logic [19:0] bcd_out,
    output logic [6:0]  led1,
    output logic [6:0]  led2,
    output logic [6:0]  led3,
    output logic [6:0]  led4,
    output logic [6:0]  led5,
    output logic [6:0]  led6
);

    // Active-low segment patterns (gfedcba).
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StUpdate
    } state_t;

    state_t      state_q;
    logic        sign_q;
    logic [15:0] mag_q;
    logic [19:0] bcd_q;
    logic [3:0]  cnt_q;

    logic [19:0] bcd_adj;
    logic [19:0] bcd_shift;
    logic [15:0] mag_shift;
    logic [15:0] mag_load;
    logic        sign_load;

    logic [6:0]  seg_d1, seg_d2, seg_d3, seg_d4, seg_d5, seg_d6;
    logic        blank5, blank4, blank3, blank2;

    // Decimal digit to active-low segment pattern.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        unique case (d)
            4'd0:    c = 7'h40;
            4'd1:    c = 7'h79;
            4'd2:    c = 7'h24;
            4'd3:    c = 7'h30;
            4'd4:    c = 7'h19;
            4'd5:    c = 7'h12;
            4'd6:    c = 7'h02;
            4'd7:    c = 7'h78;
            4'd8:    c = 7'h00;
            4'd9:    c = 7'h10;
            default: c = SEG_BLANK;  // unreachable: BCD digits stay <= 9
        endcase
        return c;
    endfunction

    // Apply the board's segment polarity to an active-low pattern.
    function automatic logic [6:0] seg_pol(input logic [6:0] c);
        return SEG_ACTIVE_LOW ? c : ~c;
    endfunction

    // Sign/magnitude split at acceptance. 0x8000 negates to 0x8000, which
    // reads correctly as 32768 when the result is taken as unsigned.
    assign sign_load = sample_data[15] & SIGNED_IN;
    assign mag_load  = sign_load ? (~sample_data + 16'd1) : sample_data;

    // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd, mag} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_shift = {bcd_adj[18:0], mag_q[15]};
    assign mag_shift = {mag_q[14:0], 1'b0};

    // Leading-zero blanking cascades down from the top digit. led1 is never blanked.
    assign blank5 = BLANK_LZ && (bcd_q[19:16] == 4'd0);
    assign blank4 = blank5 && (bcd_q[15:12] == 4'd0);
    assign blank3 = blank4 && (bcd_q[11:8] == 4'd0);
    assign blank2 = blank3 && (bcd_q[7:4] == 4'd0);

    always_comb begin
        seg_d1 = seg_pol(seg_code(bcd_q[3:0]));
        seg_d2 = seg_pol(blank2 ? SEG_BLANK : seg_code(bcd_q[7:4]));
        seg_d3 = seg_pol(blank3 ? SEG_BLANK : seg_code(bcd_q[11:8]));
        seg_d4 = seg_pol(blank4 ? SEG_BLANK : seg_code(bcd_q[15:12]));
        seg_d5 = seg_pol(blank5 ? SEG_BLANK : seg_code(bcd_q[19:16]));
        seg_d6 = seg_pol(sign_q ? SEG_MINUS : SEG_BLANK);
    end

    always_ff @(posedge clk_50Mhz) begin
        if (reset) begin
            state_q      <= StIdle;
            sign_q       <= 1'b0;
            mag_q        <= 16'd0;
            bcd_q        <= 20'd0;
            cnt_q        <= 4'd0;
            sample_ready <= 1'b1;
            disp_valid   <= 1'b0;
            bcd_out      <= 20'd0;
            led1         <= seg_pol(SEG_BLANK);
            led2         <= seg_pol(SEG_BLANK);
            led3         <= seg_pol(SEG_BLANK);
            led4         <= seg_pol(SEG_BLANK);
            led5         <= seg_pol(SEG_BLANK);
            led6         <= seg_pol(SEG_BLANK);
        end else begin
            disp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (sample_valid) begin
                        sign_q       <= sign_load;
                        mag_q        <= mag_load;
                        bcd_q        <= 20'd0;
                        cnt_q        <= 4'd0;
                        sample_ready <= 1'b0;
                        state_q      <= StConvert;
                    end
                end
                StConvert: begin
                    bcd_q <= bcd_shift;
                    mag_q <= mag_shift;
                    cnt_q <= cnt_q + 4'd1;
                    // The 16th shift happens while cnt_q is 15.
                    if (cnt_q == 4'd15) begin
                        state_q <= StUpdate;
                    end
                end
                StUpdate: begin
                    bcd_out      <= bcd_q;
                    led1         <= seg_d1;
                    led2         <= seg_d2;
                    led3         <= seg_d3;
                    led4         <= seg_d4;
                    led5         <= seg_d5;
                    led6         <= seg_d6;
                    disp_valid   <= 1'b1;
                    sample_ready <= 1'b1;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q      <= StIdle;
                    sample_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_seg_display.sv
// Testbench for adc_seg_display. It runs three instances from the same stimulus:
// the default build, an unsigned-input build, and a build with no blanking and
// active-high segments. A scoreboard queue holds the expected display for each
// accepted sample and is checked on every disp_valid pulse.
module tb_adc_seg_display;

    typedef struct packed {
        logic [15:0] data;
        logic [19:0] bcd;
        logic [6:0]  l6, l5, l4, l3, l2, l1;
    } vec_t;

    typedef struct {
        vec_t        v;
        int unsigned due;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [15:0] sample_data;

    logic        m_ready, m_valid, u_ready, u_valid, r_ready, r_valid;
    logic [19:0] m_bcd, u_bcd, r_bcd;
    logic [6:0]  m_l1, m_l2, m_l3, m_l4, m_l5, m_l6;
    logic [6:0]  u_l1, u_l2, u_l3, u_l4, u_l5, u_l6;
    logic [6:0]  r_l1, r_l2, r_l3, r_l4, r_l5, r_l6;

    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    sb_t         sb[$];
    vec_t        tbl[8];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_seg_display u_main (
        .clk_50Mhz(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(m_ready), .disp_valid(m_valid), .bcd_out(m_bcd),
        .led1(m_l1), .led2(m_l2), .led3(m_l3), .led4(m_l4), .led5(m_l5), .led6(m_l6)
    );

    adc_seg_display #(.SIGNED_IN(1'b0)) u_uns (
        .clk_50Mhz(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(u_ready), .disp_valid(u_valid), .bcd_out(u_bcd),
        .led1(u_l1), .led2(u_l2), .led3(u_l3), .led4(u_l4), .led5(u_l5), .led6(u_l6)
    );

    adc_seg_display #(.BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b0)) u_raw (
        .clk_50Mhz(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(r_ready), .disp_valid(r_valid), .bcd_out(r_bcd),
        .led1(r_l1), .led2(r_l2), .led3(r_l3), .led4(r_l4), .led5(r_l5), .led6(r_l6)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Decimal model of the display for arbitrary parameter settings.
    function automatic vec_t model(input logic [15:0] d, input bit sgn, input bit blz,
                                   input bit al);
        vec_t        r;
        int          m;
        int          dig[5];
        bit          neg;
        bit          bl;
        logic [6:0]  c[6];
        neg = sgn && d[15];
        m   = neg ? (65536 - int'(d)) : int'(d);
        for (int i = 0; i < 5; i++) begin
            dig[i] = m % 10;
            m      = m / 10;
        end
        bl = blz;
        for (int k = 4; k >= 1; k--) begin
            bl   = bl && (dig[k] == 0);
            c[k] = bl ? 7'h7F : seg_ref(dig[k]);
        end
        c[0] = seg_ref(dig[0]);
        c[5] = neg ? 7'h3F : 7'h7F;
        if (!al) begin
            for (int k = 0; k < 6; k++) c[k] = ~c[k];
        end
        r.data = d;
        r.bcd  = {dig[4][3:0], dig[3][3:0], dig[2][3:0], dig[1][3:0], dig[0][3:0]};
        r.l1 = c[0]; r.l2 = c[1]; r.l3 = c[2]; r.l4 = c[3]; r.l5 = c[4]; r.l6 = c[5];
        return r;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_disp_valid: got pulse at cycle %0d, expected none", cyc);
            end else begin
                sb_t  e;
                vec_t um, rm;
                e  = sb.pop_front();
                um = model(e.v.data, 1'b0, 1'b1, 1'b1);
                rm = model(e.v.data, 1'b1, 1'b0, 1'b0);
                check("latency_cycle", 64'(cyc), 64'(e.due));
                check("bcd_out", 64'(m_bcd), 64'(e.v.bcd));
                check("leds_6to1", {m_l6, m_l5, m_l4, m_l3, m_l2, m_l1},
                      {e.v.l6, e.v.l5, e.v.l4, e.v.l3, e.v.l2, e.v.l1});
                check("ready_with_pulse", 64'(m_ready), 64'd1);
                check("uns_bcd", 64'(u_bcd), 64'(um.bcd));
                check("uns_leds", {u_l6, u_l5, u_l4, u_l3, u_l2, u_l1},
                      {um.l6, um.l5, um.l4, um.l3, um.l2, um.l1});
                check("raw_leds", {r_l6, r_l5, r_l4, r_l3, r_l2, r_l1},
                      {rm.l6, rm.l5, rm.l4, rm.l3, rm.l2, rm.l1});
                check("pulse_align", {62'd0, u_valid, r_valid}, 64'd3);
            end
        end
    end

    // Wait for sample_ready, present one sample for one edge (E0) and optionally
    // push its expected display.
    task automatic send(input vec_t v, input bit push);
        int n = 0;
        @(posedge clk);
        #1;
        while (!m_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!m_ready) begin
            check("ready_timeout", 64'(m_ready), 64'd1);
            return;
        end
        sample_valid = 1'b1;
        sample_data  = v.data;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        if (push) sb.push_back('{v, cyc + 17});
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_ready"}, 64'(m_ready), 64'd1);
        check({tag, "_disp_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_bcd"}, 64'(m_bcd), 64'd0);
        check({tag, "_leds"}, {m_l6, m_l5, m_l4, m_l3, m_l2, m_l1}, {6{7'h7F}});
        check({tag, "_raw_leds"}, {r_l6, r_l5, r_l4, r_l3, r_l2, r_l1}, 64'd0);
    endtask

    initial begin
        //                data      bcd         l6     l5     l4     l3     l2     l1
        tbl[0] = '{16'h04D2, 20'h01234, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
        tbl[1] = '{16'h8000, 20'h32768, 7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00};
        tbl[2] = '{16'hFFFF, 20'h00001, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79};
        tbl[3] = '{16'h0000, 20'h00000, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        tbl[4] = '{16'h7FFF, 20'h32767, 7'h7F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h78};
        tbl[5] = '{16'hFF9C, 20'h00100, 7'h3F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40};
        tbl[6] = '{16'h2710, 20'h10000, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40};
        tbl[7] = '{16'hD8F1, 20'h09999, 7'h3F, 7'h7F, 7'h10, 7'h10, 7'h10, 7'h10};

        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("reset");

        // Table vectors, issued back to back: each send waits for sample_ready.
        for (int i = 0; i < 8; i++) send(tbl[i], 1'b1);
        drain();

        // Busy drop: 0x0009 is offered on edges E3..E10 while converting 0x0001.
        send('{16'h0001, 20'h00001, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79}, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        sample_valid = 1'b1;
        sample_data  = 16'h0009;
        check("busy_ready_low", 64'(m_ready), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        sample_valid = 1'b0;
        drain();

        // Reset at E8 aborts the 0x1234 conversion.
        send('{16'h1234, 20'h04660, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("midreset");
        repeat (25) @(posedge clk);
        check("midreset_hold_bcd", 64'(m_bcd), 64'd0);
        send('{16'h0064, 20'h00100, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
